// File: rtl/fetch_btb_unit_pkg.sv
// Shared fetch-stage types and PC helpers for the BTB-predicting fetch unit.
// The BTB entry layout depends on the BTB depth, so it is declared in the btb module itself.
package fetch_btb_unit_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_pred_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_btb_unit_btb.sv
// Direct-mapped BTB with saturating direction counters: one combinational lookup port, one update port.
// Lookup reflects pre-edge contents; updates land on the rising edge.
module fetch_btb_unit_btb
  import fetch_btb_unit_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] lookup_pc,
  output fetch_pred_t pred,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_RESET  = CTR_W'(1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [CTR_W-1:0] ctr;
  } btb_entry_t;

  btb_entry_t mem [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t       lk_ent, up_ent;
  logic             lk_hit, up_hit;
  logic [CTR_W-1:0] ctr_next;
  logic [1:0]       unused_upd_pc_bits;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign lk_ent = mem[lk_idx];
  assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);

  always_comb begin
    pred             = '0;
    pred.pred_taken  = lk_hit && lk_ent.ctr[CTR_W-1];
    pred.pred_target = pred.pred_taken ? lk_ent.target : pc_plus4(lookup_pc);
  end

  // Branch PCs are word aligned; the byte offset never reaches the index or tag.
  assign unused_upd_pc_bits = upd_pc[1:0];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];
  assign up_ent = mem[up_idx];
  assign up_hit = up_ent.valid && (up_ent.tag == up_tag);

  always_comb begin
    ctr_next = up_ent.ctr;
    if (upd_taken && (up_ent.ctr != '1))
      ctr_next = up_ent.ctr + CTR_W'(1);
    else if (!upd_taken && (up_ent.ctr != '0))
      ctr_next = up_ent.ctr - CTR_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        mem[i]     <= '0;
        mem[i].ctr <= CTR_RESET;
      end
    end else if (upd_en) begin
      if (up_hit) begin
        mem[up_idx].ctr <= ctr_next;
        if (upd_taken)
          mem[up_idx].target <= upd_target;
      end else if (upd_taken) begin
        mem[up_idx].valid  <= 1'b1;
        mem[up_idx].tag    <= up_tag;
        mem[up_idx].target <= upd_target;
        mem[up_idx].ctr    <= CTR_WEAK_T;
      end
    end
  end

endmodule

// File: rtl/fetch_btb_unit.sv
// Fetch stage: PC register, icache request, BTB-driven next-PC and the IF/ID register.
// A MEM-stage mispredict redirects the PC in one edge and squashes IF/ID, overriding stall.
module fetch_btb_unit
  import fetch_btb_unit_pkg::*;
#(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned CTR_W       = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_is_branch,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_mispredict,
  input  logic [31:0] resolve_npc,
  output logic [31:0] imemaddr,
  output logic        imemREN,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_pred_taken,
  output logic [31:0] ifid_pred_target,
  output logic [31:0] mispredict_cnt
);

  logic [31:0] pc;
  fetch_pred_t pred;
  logic        redirect;

  assign redirect = resolve_valid && resolve_mispredict;
  assign imemaddr = pc;
  assign imemREN  = 1'b1;

  fetch_btb_unit_btb #(
    .ENTRIES (BTB_ENTRIES),
    .CTR_W   (CTR_W)
  ) u_btb (
    .CLK        (CLK),
    .RST        (RST),
    .lookup_pc  (pc),
    .pred       (pred),
    .upd_en     (resolve_valid && resolve_is_branch),
    .upd_pc     (resolve_pc),
    .upd_taken  (resolve_taken),
    .upd_target (resolve_target)
  );

  always_ff @(posedge CLK) begin
    if (RST)
      pc <= PC_INIT;
    else if (redirect)
      pc <= resolve_npc;
    else if (!stall && ihit)
      pc <= pred.pred_target;
  end

  always_ff @(posedge CLK) begin
    if (RST || (!RST && redirect)) begin
      ifid_valid       <= 1'b0;
      ifid_instr       <= '0;
      ifid_npc         <= '0;
      ifid_pred_taken  <= 1'b0;
      ifid_pred_target <= '0;
    end else if (!stall && ihit) begin
      ifid_valid       <= 1'b1;
      ifid_instr       <= imemload;
      ifid_npc         <= pc_plus4(pc);
      ifid_pred_taken  <= pred.pred_taken;
      ifid_pred_target <= pred.pred_target;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      mispredict_cnt <= '0;
    else if (redirect && (mispredict_cnt != 32'hFFFF_FFFF))
      mispredict_cnt <= mispredict_cnt + 32'd1;
  end

endmodule
